mpu6050_i2c_responder: RTL
==========================

// Module: mpu6050_i2c_responder
// PURPOSE
// I2C target (slave) model of the MPU6050 register interface; answers GiroscopioController/i2c_master transactions.
// Used on-board as a sensor stand-in and in benches as the bus responder. Holds a 14-byte sensor window (0x3B..0x48),
// preloadable from local logic, plus WHO_AM_I. Fully synthesizable, oversampled (no SCL-clocked logic).
// PARAMETERS
// SLAVE_ADDRESS  7'h68  7-bit bus address answered; also the WHO_AM_I value ({1'b0,SLAVE_ADDRESS}).
// REG_BASE       8'h3B  first register pointer of the sensor window.
// REG_COUNT      14     bytes in the window (REG_BASE..REG_BASE+REG_COUNT-1).
// WHO_AM_I_ADDR  8'h75  read-only identity register pointer.
// PORTS
// clk           in     1  system clock; must be >= 8x SCL frequency.
// reset         in     1  synchronous, active-high reset.
// SCL_BUS       in     1  I2C clock from master (responder never stretches).
// SDA_BUS       inout  1  open-drain data; driven 1'b0 or 1'bz only.
// load_en       in     1  local write strobe into window.
// load_addr     in     8  local register pointer (ignored outside window).
// load_data     in     8  local write data.
// busy          out    1  high from START+matching address ACK until STOP/NACK end.
// bus_wr_valid  out    1  1-cycle pulse per data byte written by master.
// bus_wr_addr   out    8  register pointer of that byte.
// bus_wr_data   out    8  data of that byte.
// BEHAVIOUR
// - Reset: SDA released, busy=0, bus_wr_valid=0, bus_wr_addr=0, bus_wr_data=0, pointer=0, window cleared to 0, FSM=IDLE.
// - SCL/SDA pass 2-FF synchronizers + 1 history FF; edge/condition detect 3 clk after pin change.
// - START: SDA fall while SCL high. STOP: SDA rise while SCL high. Both recognised in every state:
//   START -> ADDR (repeated start allowed); STOP -> IDLE, SDA released next clk, busy=0. Pointer retained.
// - Data sampled on synchronized SCL rise; SDA output changes only on synchronized SCL fall.
// - FSM: IDLE, ADDR(8 bits), ACK_ADDR, PTR(8 bits), ACK_PTR, WDATA(8 bits), ACK_WDATA, RDATA(8 bits), MACK, IGNORE.
//   ADDR: shift 7 addr + R/W. Mismatch -> IGNORE (no ACK, SDA released until next START/STOP).
//   Match -> ACK_ADDR: drive SDA low for 9th SCL, busy=1; then W -> PTR, R -> load byte, RDATA.
//   PTR: byte becomes pointer; ACK_PTR; then WDATA.
//   WDATA: byte complete -> ACK_WDATA, write window if in range, pulse bus_wr_valid, pointer+1.
//   RDATA: MSB first; drive 0 for bit=0, release for bit=1; then MACK samples master on 9th rise:
//   ACK(0) -> pointer+1, load next byte, RDATA; NACK(1) -> IGNORE (wait STOP/START), busy stays until STOP.
// - Read data: window byte if REG_BASE<=ptr<REG_BASE+REG_COUNT; {1'b0,SLAVE_ADDRESS} at WHO_AM_I_ADDR; else 8'h00.
// - Out-of-window bus writes: ACKed, pulse bus_wr_valid, storage unchanged.
// - Pointer 8-bit, wraps 8'hFF -> 8'h00.
// - load_en same clk as bus write to same register: local load wins, bus byte dropped (pulse still issued).
// - load_en to a register mid-read takes effect only on next byte fetch (byte captured at RDATA entry).
// - Reset mid-transaction: SDA released on next clk edge, all state to reset values.
// TESTING
// 1 load 0x3B=0x12,0x3C=0x34; master W ptr 0x3B, Sr, R 2 bytes (ACK,NACK), STOP -> SDA 0x12,0x34; busy falls after STOP.
// 2 master addresses 7'h69 -> SDA high at 9th SCL, busy=0, no bus_wr_valid, next valid txn works.
// 3 W ptr 0x75, Sr, R 1 byte NACK -> 0x68; ptr 0x10 read -> 0x00.
// 4 W ptr 0x40, data 0xAB,0xCD -> bus_wr_valid x2 (0x40/0xAB, 0x41/0xCD); read back 0xAB,0xCD.
// 5 W ptr 0xFF, data 0x01,0x02 -> bus_wr_addr 0xFF then 0x00 (wrap), window unchanged.
// 6 reset high mid-RDATA bit 4 -> SDA released next clk, busy=0, window=0; STOP mid-byte -> IDLE, SDA released.

Source files
------------

// File: rtl/mpu6050_i2c_responder.sv
// mpu6050_i2c_responder: oversampled I2C target presenting an MPU6050-style
// register map (14-byte sensor window plus WHO_AM_I). SCL/SDA are sampled on
// clk, so no logic is clocked by SCL.
module mpu6050_i2c_responder #(
  parameter logic [6:0] SLAVE_ADDRESS = 7'h68,
  parameter logic [7:0] REG_BASE      = 8'h3B,
  parameter int         REG_COUNT     = 14,
  parameter logic [7:0] WHO_AM_I_ADDR = 8'h75
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCL_BUS,
  inout  wire        SDA_BUS,
  input  logic       load_en,
  input  logic [7:0] load_addr,
  input  logic [7:0] load_data,
  output logic       busy,
  output logic       bus_wr_valid,
  output logic [7:0] bus_wr_addr,
  output logic [7:0] bus_wr_data
);

  localparam int         IDX_W   = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [8:0] REG_END = {1'b0, REG_BASE} + 9'(REG_COUNT);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ACK_ADDR, S_PTR, S_ACK_PTR,
    S_WDATA, S_ACK_WDATA, S_RDATA, S_MACK, S_IGNORE
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] ptr_reg, ptr_next;
  logic [3:0] bit_cnt_reg, bit_cnt_next;
  logic       sda_low_reg, sda_low_next;
  logic       busy_reg, busy_next;
  logic       rw_reg, rw_next;
  logic       bus_wr_valid_reg;
  logic [7:0] bus_wr_addr_reg, bus_wr_data_reg;
  logic       wr_en_next;
  logic [7:0] wr_addr_next, wr_data_next;

  logic scl_meta_reg, scl_sync_reg, scl_hist_reg;
  logic sda_meta_reg, sda_sync_reg, sda_hist_reg;
  logic scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] shifted;

  logic [7:0]       window_bytes [REG_COUNT];
  logic [IDX_W-1:0] rd_idx;
  logic             in_window;
  logic [7:0]       rd_byte;

  // Open-drain pad: only ever pull low or release.
  assign SDA_BUS = sda_low_reg ? 1'b0 : 1'bz;

  // Two-stage synchronizers plus one history stage for edge/condition detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_meta_reg <= 1'b1;
      scl_sync_reg <= 1'b1;
      scl_hist_reg <= 1'b1;
      sda_meta_reg <= 1'b1;
      sda_sync_reg <= 1'b1;
      sda_hist_reg <= 1'b1;
    end else begin
      scl_meta_reg <= SCL_BUS;
      scl_sync_reg <= scl_meta_reg;
      scl_hist_reg <= scl_sync_reg;
      sda_meta_reg <= SDA_BUS;
      sda_sync_reg <= sda_meta_reg;
      sda_hist_reg <= sda_sync_reg;
    end
  end

  assign scl_rise  = scl_sync_reg & ~scl_hist_reg;
  assign scl_fall  = ~scl_sync_reg & scl_hist_reg;
  // SCL must be stable high across the SDA edge for START/STOP.
  assign start_det = scl_sync_reg & scl_hist_reg & sda_hist_reg & ~sda_sync_reg;
  assign stop_det  = scl_sync_reg & scl_hist_reg & ~sda_hist_reg & sda_sync_reg;
  assign shifted   = {shift_reg[6:0], sda_sync_reg};

  for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_window
    localparam logic [7:0] ENTRY_ADDR = REG_BASE + 8'(gi);
    logic [7:0] byte_reg;
    // Window byte: a local load beats a bus write landing in the same cycle.
    always_ff @(posedge clk) begin
      if (reset) begin
        byte_reg <= 8'h00;
      end else if (load_en && load_addr == ENTRY_ADDR) begin
        byte_reg <= load_data;
      end else if (wr_en_next && wr_addr_next == ENTRY_ADDR) begin
        byte_reg <= wr_data_next;
      end
    end
    assign window_bytes[gi] = byte_reg;
  end

  assign in_window = ({1'b0, ptr_reg} >= {1'b0, REG_BASE}) && ({1'b0, ptr_reg} < REG_END);
  assign rd_idx    = IDX_W'(ptr_reg - REG_BASE);

  // Byte returned for the current pointer; captured when a read byte starts.
  always_comb begin
    rd_byte = 8'h00;
    if (in_window) begin
      rd_byte = window_bytes[rd_idx];
    end else if (ptr_reg == WHO_AM_I_ADDR) begin
      rd_byte = {1'b0, SLAVE_ADDRESS};
    end
  end

  // Protocol state register and bus-write reporting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= S_IDLE;
      shift_reg        <= 8'h00;
      ptr_reg          <= 8'h00;
      bit_cnt_reg      <= 4'd0;
      sda_low_reg      <= 1'b0;
      busy_reg         <= 1'b0;
      rw_reg           <= 1'b0;
      bus_wr_valid_reg <= 1'b0;
      bus_wr_addr_reg  <= 8'h00;
      bus_wr_data_reg  <= 8'h00;
    end else begin
      state_reg        <= state_next;
      shift_reg        <= shift_next;
      ptr_reg          <= ptr_next;
      bit_cnt_reg      <= bit_cnt_next;
      sda_low_reg      <= sda_low_next;
      busy_reg         <= busy_next;
      rw_reg           <= rw_next;
      bus_wr_valid_reg <= wr_en_next;
      if (wr_en_next) begin
        bus_wr_addr_reg <= wr_addr_next;
        bus_wr_data_reg <= wr_data_next;
      end
    end
  end

  // Next-state logic: bits sampled on SCL rise, SDA only changed on SCL fall.
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    ptr_next     = ptr_reg;
    bit_cnt_next = bit_cnt_reg;
    sda_low_next = sda_low_reg;
    busy_next    = busy_reg;
    rw_next      = rw_reg;
    wr_en_next   = 1'b0;
    wr_addr_next = ptr_reg;
    wr_data_next = shifted;

    if (start_det) begin
      state_next   = S_ADDR;
      bit_cnt_next = 4'd0;
      sda_low_next = 1'b0;
    end else if (stop_det) begin
      state_next   = S_IDLE;
      sda_low_next = 1'b0;
      busy_next    = 1'b0;
    end else begin
      unique case (state_reg)
        S_ADDR: if (scl_rise) begin
          shift_next   = shifted;
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == 4'd7) begin
            if (shifted[7:1] == SLAVE_ADDRESS) begin
              rw_next    = shifted[0];
              busy_next  = 1'b1;
              state_next = S_ACK_ADDR;
            end else begin
              busy_next  = 1'b0;
              state_next = S_IGNORE;
            end
          end
        end
        // First fall after the byte asserts ACK, the following fall ends it.
        S_ACK_ADDR: if (scl_fall) begin
          bit_cnt_next = 4'd0;
          if (!sda_low_reg) begin
            sda_low_next = 1'b1;
          end else if (rw_reg) begin
            shift_next   = rd_byte;
            sda_low_next = ~rd_byte[7];
            state_next   = S_RDATA;
          end else begin
            sda_low_next = 1'b0;
            state_next   = S_PTR;
          end
        end
        S_PTR: if (scl_rise) begin
          shift_next   = shifted;
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == 4'd7) begin
            ptr_next   = shifted;
            state_next = S_ACK_PTR;
          end
        end
        S_ACK_PTR, S_ACK_WDATA: if (scl_fall) begin
          bit_cnt_next = 4'd0;
          if (!sda_low_reg) begin
            sda_low_next = 1'b1;
          end else begin
            sda_low_next = 1'b0;
            state_next   = S_WDATA;
          end
        end
        S_WDATA: if (scl_rise) begin
          shift_next   = shifted;
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == 4'd7) begin
            wr_en_next = 1'b1;
            ptr_next   = ptr_reg + 8'd1;
            state_next = S_ACK_WDATA;
          end
        end
        S_RDATA: begin
          if (scl_rise) begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_reg == 4'd8) begin
              bit_cnt_next = 4'd0;
              sda_low_next = 1'b0;
              state_next   = S_MACK;
            end else begin
              shift_next   = {shift_reg[6:0], 1'b0};
              sda_low_next = ~shift_reg[6];
            end
          end
        end
        // bit_cnt flags a master ACK so the next byte is fetched on the fall.
        S_MACK: begin
          if (scl_rise) begin
            if (!sda_sync_reg) begin
              ptr_next     = ptr_reg + 8'd1;
              bit_cnt_next = 4'd1;
            end else begin
              state_next = S_IGNORE;
            end
          end else if (scl_fall && bit_cnt_reg == 4'd1) begin
            bit_cnt_next = 4'd0;
            shift_next   = rd_byte;
            sda_low_next = ~rd_byte[7];
            state_next   = S_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy         = busy_reg;
  assign bus_wr_valid = bus_wr_valid_reg;
  assign bus_wr_addr  = bus_wr_addr_reg;
  assign bus_wr_data  = bus_wr_data_reg;

endmodule
